// File: rtl/break_fetch_sequencer_pkg.sv
// Shared state encoding and wren code helpers for the break-fetch sequencer.
package break_fetch_sequencer_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ISSUE   = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_PRESENT = 3'd3;
  localparam logic [2:0] ST_DRAIN   = 3'd4;
  localparam logic [2:0] ST_OUTPUT  = 3'd5;

  // Full-width codes; the sequencer truncates them to its wren width.
  localparam logic [31:0] WREN_IDLE   = 32'h0000_0000;
  localparam logic [31:0] WREN_SELECT = 32'hFFFF_FFFF;

  function automatic logic [31:0] wren_onehot(input logic [31:0] idx);
    return 32'd1 << idx;
  endfunction

endpackage

// File: rtl/break_fetch_sequencer.sv
// Fetches occurrence data per clause candidate and sequences the break selector; optional BREAK_FETCH_STATS_EN counters.
// Latency: NSAT*(L+2)+2 cycles from clause accept to flip_valid_o for uniform memory latency L.
// Backpressure: one clause in flight; clause_ready_o only in IDLE, flip held until flip_ready_i.
module break_fetch_sequencer
  import break_fetch_sequencer_pkg::*;
#(
  parameter int MAX_CLAUSES_PER_VARIABLE = 20,
  parameter int NSAT                     = 3,
  parameter int NSAT_BITS                = 2,
  parameter int VAR_BITS                 = 16,
  parameter int NSAT_IDX_BITS            = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clause_valid_i,
  output logic                         clause_ready_o,
  input  logic [NSAT*VAR_BITS-1:0]     clause_vars_i,
  input  logic [NSAT-1:0]              clause_lit_valid_i,
  output logic                         mem_req_o,
  output logic [VAR_BITS-1:0]          mem_addr_o,
  input  logic                         mem_rsp_valid_i,
  input  logic [MAX_CLAUSES_PER_VARIABLE-1:0] mem_rsp_broken_i,
  input  logic [MAX_CLAUSES_PER_VARIABLE-1:0] mem_rsp_mask_i,
  output logic [MAX_CLAUSES_PER_VARIABLE-1:0] clause_broken_o,
  output logic [MAX_CLAUSES_PER_VARIABLE-1:0] mask_bits_o,
  output logic [NSAT_BITS-1:0]         wren_o,
  output logic [NSAT-1:0]              bv_valid_o,
  input  logic [NSAT_BITS-1:0]         select_i,
  output logic                         flip_valid_o,
  output logic [VAR_BITS-1:0]          flip_var_o,
  input  logic                         flip_ready_i
`ifdef BREAK_FETCH_STATS_EN
  ,
  output logic [31:0]                  flip_count_o,
  output logic [31:0]                  stall_cycles_o
`endif
);

  logic [2:0]               state;
  logic [NSAT_IDX_BITS-1:0] k;
  logic [VAR_BITS-1:0]      vars_q [NSAT];
  logic [NSAT-1:0]          lit_q;
  logic                     k_last;
  logic                     sel_ok;

  assign k_last     = (int'(k) >= NSAT - 1);
  assign sel_ok     = (int'(select_i) < NSAT);
  assign bv_valid_o = lit_q;

  // Request and wren codes decode straight from state so each lasts exactly one cycle.
  assign mem_req_o  = (state == ST_ISSUE) && lit_q[k];
  assign mem_addr_o = mem_req_o ? vars_q[k] : '0;

  always_comb begin
    wren_o = NSAT_BITS'(WREN_IDLE);
    if (state == ST_PRESENT) begin
      wren_o = k_last ? NSAT_BITS'(WREN_SELECT) : NSAT_BITS'(wren_onehot(32'(k)));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= ST_IDLE;
      k               <= '0;
      lit_q           <= '0;
      clause_ready_o  <= 1'b0;
      clause_broken_o <= '0;
      mask_bits_o     <= '0;
      flip_valid_o    <= 1'b0;
      flip_var_o      <= '0;
      for (int i = 0; i < NSAT; i++) vars_q[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          clause_ready_o <= 1'b1;
          if (clause_valid_i && clause_ready_o) begin
            for (int i = 0; i < NSAT; i++) vars_q[i] <= clause_vars_i[i*VAR_BITS +: VAR_BITS];
            lit_q          <= clause_lit_valid_i;
            k              <= '0;
            clause_ready_o <= 1'b0;
            state          <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (lit_q[k]) begin
            state <= ST_WAIT;
          end else begin
            // Empty slot contributes no broken clauses to the selector.
            clause_broken_o <= '0;
            mask_bits_o     <= '0;
            state           <= ST_PRESENT;
          end
        end
        ST_WAIT: begin
          if (mem_rsp_valid_i) begin
            clause_broken_o <= mem_rsp_broken_i;
            mask_bits_o     <= mem_rsp_mask_i;
            state           <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (!k_last) begin
            k     <= k + 1'b1;
            state <= ST_ISSUE;
          end else begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          flip_var_o   <= sel_ok ? vars_q[select_i] : '0;
          flip_valid_o <= 1'b1;
          state        <= ST_OUTPUT;
        end
        ST_OUTPUT: begin
          if (flip_ready_i) begin
            flip_valid_o   <= 1'b0;
            lit_q          <= '0;
            clause_ready_o <= 1'b1;
            state          <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef BREAK_FETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      flip_count_o   <= '0;
      stall_cycles_o <= '0;
    end else begin
      if (flip_valid_o && flip_ready_i && (flip_count_o != 32'hFFFF_FFFF))
        flip_count_o <= flip_count_o + 32'd1;
      if ((state == ST_WAIT) && (stall_cycles_o != 32'hFFFF_FFFF))
        stall_cycles_o <= stall_cycles_o + 32'd1;
    end
  end
`endif

endmodule
